// File: rtl/puf_host_link_if.sv
// Host <-> PUF SoC link bundle: request, serial rx/tx handshakes and response.
// master = host/SoC stimulus side, slave = the puf_host_link initiator.
interface puf_host_link_if #(
    parameter int CHAL_BITS = 8,
    parameter int DEBUG_MOD = 133
) ();
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic [CHAL_BITS-1:0] i_req_chal;
    logic                 i_req_mode;
    logic                 o_start;
    logic                 o_op_mode;
    logic                 i_rx_ready;
    logic                 o_rx_valid;
    logic                 o_rx_data;
    logic                 o_tx_ready;
    logic                 i_tx_valid;
    logic                 i_tx_data;
    logic                 o_rsp_valid;
    logic [DEBUG_MOD-1:0] o_rsp_data;
    logic                 o_rsp_timeout;
    logic                 o_busy;

    modport master (
        output i_req_valid, i_req_chal, i_req_mode, i_rx_ready, i_tx_valid, i_tx_data,
        input  o_req_ready, o_start, o_op_mode, o_rx_valid, o_rx_data, o_tx_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_timeout, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_chal, i_req_mode, i_rx_ready, i_tx_valid, i_tx_data,
        output o_req_ready, o_start, o_op_mode, o_rx_valid, o_rx_data, o_tx_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_timeout, o_busy
    );
endinterface

// File: rtl/puf_host_link.sv
// Host-side initiator for the PUF SoC serial link: sends a challenge bit-serially,
// collects the response frame and reports it with done/timeout status.
module puf_host_link #(
    parameter int CHAL_BITS   = 8,
    parameter int NORM_MOD    = 34,
    parameter int DEBUG_MOD   = 133,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic            clk,
    input logic            rst,
    puf_host_link_if.slave bus
);
    localparam int MAX_LEN = (DEBUG_MOD > CHAL_BITS) ? DEBUG_MOD : CHAL_BITS;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CHAL_LAST  = CNT_W'(CHAL_BITS - 1);
    localparam logic [CNT_W-1:0] NORM_LAST  = CNT_W'(NORM_MOD - 1);
    localparam logic [CNT_W-1:0] DEBUG_LAST = CNT_W'(DEBUG_MOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, START, SEND, RECV, DONE} state_t;

    state_t               state;
    logic [CHAL_BITS-1:0] chal_sr;
    logic [CNT_W-1:0]     bit_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [DEBUG_MOD-1:0] rsp_data;
    logic                 req_ready, start, op_mode, rx_valid, tx_ready;
    logic                 rsp_valid, rsp_timeout, busy;

    logic [CNT_W-1:0] frame_last;
    logic             rx_xfer, tx_xfer;

    assign frame_last = op_mode ? DEBUG_LAST : NORM_LAST;
    // rx_valid/tx_ready are only high in SEND/RECV, so stray peer strobes are ignored.
    assign rx_xfer    = rx_valid && bus.i_rx_ready;
    assign tx_xfer    = tx_ready && bus.i_tx_valid;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values; blocking here would make transitions depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            chal_sr     <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            rsp_data    <= '0;
            req_ready   <= 1'b1;
            start       <= 1'b0;
            op_mode     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            start     <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        chal_sr   <= bus.i_req_chal;
                        op_mode   <= bus.i_req_mode;
                        start     <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    rsp_data    <= '0;
                    rsp_timeout <= 1'b0;
                    bit_cnt     <= '0;
                    tmo_cnt     <= '0;
                    rx_valid    <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (rx_xfer) begin
                        tmo_cnt <= '0;
                        chal_sr <= {chal_sr[CHAL_BITS-2:0], 1'b0};
                        if (bit_cnt == CHAL_LAST) begin
                            bit_cnt  <= '0;
                            rx_valid <= 1'b0;
                            tx_ready <= 1'b1;
                            state    <= RECV;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        rx_valid    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RECV: begin
                    if (tx_xfer) begin
                        tmo_cnt  <= '0;
                        rsp_data <= {rsp_data[DEBUG_MOD-2:0], bus.i_tx_data};
                        if (bit_cnt == frame_last) begin
                            tx_ready  <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tx_ready    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    op_mode   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_start       = start;
    assign bus.o_op_mode     = op_mode;
    assign bus.o_rx_valid    = rx_valid;
    assign bus.o_rx_data     = chal_sr[CHAL_BITS-1];
    assign bus.o_tx_ready    = tx_ready;
    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_data    = rsp_data;
    assign bus.o_rsp_timeout = rsp_timeout;
    assign bus.o_busy        = busy;
endmodule

// File: tb/tb_puf_host_link.sv
// Scoreboard bench for puf_host_link: stimulus queues expected rx bits and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_puf_host_link;
    localparam int CB = 8;
    localparam int DM = 133;

    typedef struct {
        logic [DM-1:0] data;
        logic          tmo;
        logic          mode;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    puf_host_link_if #(.CHAL_BITS(CB), .DEBUG_MOD(DM)) bus ();

    puf_host_link #(
        .CHAL_BITS(CB), .NORM_MOD(34), .DEBUG_MOD(DM), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsp_t exp_rsp_q[$];
    logic exp_rx_q[$];
    logic tx_src_q[$];

    int checks = 0;
    int failures = 0;
    int accept_cnt = 0, accept_cyc = 0, start_cnt = 0, start_lat = 0;
    int rsp_seen = 0, rsp_lat = 0;
    logic bp_mode = 1'b0;

    task automatic check(input string name, input logic [DM-1:0] act, input logic [DM-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic prev_ready;
        rsp_t r;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.i_req_valid && bus.o_req_ready) begin
                    accept_cnt++;
                    accept_cyc = cyc;
                end
                if (bus.o_start) begin
                    start_cnt++;
                    start_lat = cyc - accept_cyc;
                    check("start_after_idle", DM'(prev_ready), DM'(1));
                end
                if (bus.o_rx_valid && bus.i_rx_ready) begin
                    if (exp_rx_q.size() == 0) check("unexpected_rx", DM'(1), DM'(0));
                    else check("rx_bit", DM'(bus.o_rx_data), DM'(exp_rx_q.pop_front()));
                end
                if (bus.o_rsp_valid) begin
                    rsp_seen++;
                    rsp_lat = cyc - accept_cyc;
                    if (exp_rsp_q.size() == 0) begin
                        check("unexpected_rsp", DM'(1), DM'(0));
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_data", bus.o_rsp_data, r.data);
                        check("rsp_timeout", DM'(bus.o_rsp_timeout), DM'(r.tmo));
                        check("op_mode_held", DM'(bus.o_op_mode), DM'(r.mode));
                    end
                end
                prev_ready = bus.o_req_ready;
            end
        end
    end

    // SoC peer model: serves challenge/response handshakes, optional backpressure
    initial begin
        logic tx_x, allow;
        int   gap_run;
        gap_run = 0;
        bus.i_rx_ready = 1'b0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = 1'b0;
        forever begin
            @(negedge clk);
            tx_x = bus.i_tx_valid && bus.o_tx_ready;
            @(posedge clk);
            #1;
            if (tx_x && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
            bus.i_rx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
            allow = !bp_mode || ($urandom_range(0, 2) != 0) || (gap_run >= 2);
            gap_run = allow ? 0 : gap_run + 1;
            bus.i_tx_valid = (tx_src_q.size() > 0) && allow;
            bus.i_tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 1'b0;
        end
    end

    task automatic push_exp(input logic [CB-1:0] chal, input logic mode, input logic [DM-1:0] tx_bits,
                            input int n_tx, input logic [DM-1:0] exp_data, input logic exp_tmo);
        rsp_t r;
        for (int i = CB - 1; i >= 0; i--) exp_rx_q.push_back(chal[i]);
        for (int i = n_tx - 1; i >= 0; i--) tx_src_q.push_back(tx_bits[i]);
        r.data = exp_data;
        r.tmo  = exp_tmo;
        r.mode = mode;
        exp_rsp_q.push_back(r);
    endtask

    task automatic drive_req(input logic [CB-1:0] chal, input logic mode, input int n_accepts);
        int target;
        target = accept_cnt + n_accepts;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_chal  = chal;
        bus.i_req_mode  = mode;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            if (accept_cnt >= target) break;
        end
        #1;
        bus.i_req_valid = 1'b0;
        if (accept_cnt < target) check("req_accept_wait", DM'(accept_cnt), DM'(target));
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 3000 && rsp_seen < target; k++) @(posedge clk);
        if (rsp_seen < target) check("rsp_wait", DM'(rsp_seen), DM'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DM-1:0] alt, ones;
        int s0;
        rst = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.i_req_chal  = '0;
        bus.i_req_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", DM'(bus.o_req_ready), DM'(1));
        check("rst_busy", DM'(bus.o_busy), DM'(0));
        check("rst_start", DM'(bus.o_start), DM'(0));
        check("rst_rx_valid", DM'(bus.o_rx_valid), DM'(0));
        check("rst_tx_ready", DM'(bus.o_tx_ready), DM'(0));
        check("rst_rsp_valid", DM'(bus.o_rsp_valid), DM'(0));
        check("rst_rsp_data", bus.o_rsp_data, '0);
        check("rst_rsp_timeout", DM'(bus.o_rsp_timeout), DM'(0));
        check("rst_op_mode", DM'(bus.o_op_mode), DM'(0));
        rst = 1'b0;

        // Reset asserted mid-RECV drops the transfer
        ones = '1;
        for (int i = CB - 1; i >= 0; i--) exp_rx_q.push_back(((8'hF0 >> i) & 8'h01) != 0);
        for (int i = 0; i < DM; i++) tx_src_q.push_back(ones[i]);
        drive_req(8'hF0, 1'b1, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("recv_before_reset", DM'(bus.o_tx_ready), DM'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_req_ready", DM'(bus.o_req_ready), DM'(1));
        check("mid_rst_tx_ready", DM'(bus.o_tx_ready), DM'(0));
        check("mid_rst_busy", DM'(bus.o_busy), DM'(0));
        @(negedge clk);
        #1;
        tx_src_q.delete();
        repeat (40) @(posedge clk);
        check("no_rsp_after_reset", DM'(rsp_seen), DM'(0));

        // Normal frame, zero-wait peer, latency
        push_exp(8'hA5, 1'b0, DM'(34'h2DEADBEEF), 34, DM'(34'h2DEADBEEF), 1'b0);
        drive_req(8'hA5, 1'b0, 1);
        wait_rsp(1);
        check("start_latency", DM'(start_lat), DM'(1));
        check("rsp_latency", DM'(rsp_lat), DM'(44));
        check("idle_after_done", DM'(bus.o_req_ready), DM'(1));

        // Debug frame: 133 alternating bits, first bit 1
        for (int i = 0; i < DM; i++) alt[i] = (i % 2 == 0);
        push_exp(8'h69, 1'b1, alt, DM, alt, 1'b0);
        drive_req(8'h69, 1'b1, 1);
        wait_rsp(2);

        // Backpressure on both serial ports
        bp_mode = 1'b1;
        push_exp(8'h3C, 1'b0, DM'(34'h123456789), 34, DM'(34'h123456789), 1'b0);
        drive_req(8'h3C, 1'b0, 1);
        wait_rsp(3);
        bp_mode = 1'b0;

        // Timeout after 10 response bits
        push_exp(8'h5A, 1'b0, DM'(10'h34E), 10, DM'(10'h34E), 1'b1);
        drive_req(8'h5A, 1'b0, 1);
        wait_rsp(4);

        // Back-to-back with request held high
        s0 = start_cnt;
        push_exp(8'hC3, 1'b0, DM'(34'h300000001), 34, DM'(34'h300000001), 1'b0);
        push_exp(8'hC3, 1'b0, DM'(34'h0ABCD0123), 34, DM'(34'h0ABCD0123), 1'b0);
        drive_req(8'hC3, 1'b0, 2);
        wait_rsp(6);
        check("b2b_start_pulses", DM'(start_cnt - s0), DM'(2));

        repeat (5) @(posedge clk);
        check("rsp_q_drained", DM'(exp_rsp_q.size()), DM'(0));
        check("rx_q_drained", DM'(exp_rx_q.size()), DM'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
